// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage for the 5-stage MIPS pipeline. Owns
//               the PC, handshakes with instruction memory and feeds IF/ID
//               with {instruction, PC+4}, inserting NOP bubbles on memory
//               wait states and redirect flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instrOut,
    output logic [31:0] pcPlus4Out,
    output logic        ifidWrite,
    output logic        validOut
);

    // FETCH: request outstanding at pc.
    // HOLD : fetched word parked while the pipeline is stalled; no request.
    // DROP : a request abandoned by a redirect is still draining.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] w_pcNext;
    logic [31:0] r_holdInstr;
    logic [31:0] w_holdNext;
    logic [31:0] r_dropAddr;
    logic [31:0] w_dropAddrNext;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_target;

    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_target  = redirectTarget & c_WORD_MASK;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_holdInstr <= 32'h0;
            r_dropAddr  <= 32'h0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_holdInstr <= w_holdNext;
            r_dropAddr  <= w_dropAddrNext;
        end
    end

    // Next-state and output decode; priority is reset > redirect > stall > normal.
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_holdNext     = r_holdInstr;
        w_dropAddrNext = r_dropAddr;
        imemReq        = 1'b0;
        imemAddr       = r_pc;
        ifidWrite      = 1'b0;
        validOut       = 1'b0;
        instrOut       = 32'h0;
        pcPlus4Out     = 32'h0;

        if (!reset) begin
            imemReq    = (r_state != S_HOLD);
            // While draining, keep presenting the abandoned address so the
            // memory sees a stable request until it completes.
            imemAddr   = (r_state == S_DROP) ? r_dropAddr : r_pc;
            pcPlus4Out = w_pcPlus4;

            if (redirect) begin
                // Flush the wrong-path slot with a bubble.
                ifidWrite  = 1'b1;
                w_pcNext   = w_target;
                w_holdNext = 32'h0;
                if ((r_state != S_HOLD) && !imemReady) begin
                    w_stateNext = S_DROP;
                    if (r_state == S_FETCH) begin
                        w_dropAddrNext = r_pc;
                    end
                end else begin
                    w_stateNext = S_FETCH;
                end
            end else if (stall) begin
                case (r_state)
                    S_FETCH: begin
                        if (imemReady) begin
                            w_holdNext  = imemData;
                            w_stateNext = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        w_stateNext = S_HOLD;
                    end
                    S_DROP: begin
                        if (imemReady) begin
                            w_stateNext = S_FETCH;
                        end
                    end
                    default: begin
                        w_stateNext = S_FETCH;
                    end
                endcase
            end else begin
                ifidWrite = 1'b1;
                case (r_state)
                    S_FETCH: begin
                        if (imemReady) begin
                            validOut = 1'b1;
                            instrOut = imemData;
                            w_pcNext = w_pcPlus4;
                        end
                    end
                    S_HOLD: begin
                        validOut    = 1'b1;
                        instrOut    = r_holdInstr;
                        w_pcNext    = w_pcPlus4;
                        w_stateNext = S_FETCH;
                    end
                    S_DROP: begin
                        if (imemReady) begin
                            w_stateNext = S_FETCH;
                        end
                    end
                    default: begin
                        w_stateNext = S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A memory model with
//               programmable latency answers requests; a queue-based model
//               of the fetch rules predicts every IF/ID output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectTarget = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic [31:0] instrOut;
    logic [31:0] pcPlus4Out;
    logic        ifidWrite;
    logic        validOut;

    // Second instance exercising the wrap-around reset vector.
    logic        tieLow = 1'b0;
    logic [31:0] tieZero = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [31:0] pc4b;
    logic        wr2;
    logic        val2;

    int nAsserts = 0;
    int nFails   = 0;

    // Memory model state.
    bit          memBusy = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memCnt  = 0;
    int          latFixed = 0;
    logic        rdy;

    // Fetch-rule model state.
    logic [31:0] mPc = 32'h0;
    logic [31:0] mHeld[$];
    bit          mDropping = 1'b0;
    logic [31:0] mDropAddr = 32'h0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirectTarget), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemData(imemData), .instrOut(instrOut),
        .pcPlus4Out(pcPlus4Out), .ifidWrite(ifidWrite), .validOut(validOut)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .reset(reset), .stall(tieLow), .redirect(tieLow),
        .redirectTarget(tieZero), .imemReq(req2), .imemAddr(addr2),
        .imemReady(tieLow), .imemData(tieZero), .instrOut(instr2),
        .pcPlus4Out(pc4b), .ifidWrite(wr2), .validOut(val2)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h2210_0002 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive inputs, let memory answer, check, advance models.
    task automatic cycle(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        logic        eReq, eWr, eVal, holding;
        logic [31:0] eAddr, eInstr, ePc4;
        @(negedge clk);
        reset = rst; stall = st; redirect = rd; redirectTarget = tgt;
        #1;
        if (imemReq !== 1'b1) begin
            memBusy = 1'b0;
            rdy = 1'b0;
        end else begin
            if (memBusy) begin
                chk("addrStable", imemAddr, memAddr);
            end else begin
                memBusy = 1'b1;
                memAddr = imemAddr;
                memCnt  = (latFixed >= 0) ? latFixed : int'($urandom_range(0, 3));
            end
            rdy = (memCnt == 0);
        end
        imemReady = rdy;
        imemData  = rdy ? memWord(memAddr) : $urandom();
        #1;

        eReq = 1'b0; eWr = 1'b0; eVal = 1'b0; eAddr = 32'h0; eInstr = 32'h0; ePc4 = 32'h0;
        if (rst) begin
            mPc = 32'h0;
            mHeld.delete();
            mDropping = 1'b0;
            chk("rstInstr", instrOut, 32'h0);
        end else begin
            holding = (mHeld.size() != 0);
            eReq  = !holding;
            eAddr = mDropping ? mDropAddr : mPc;
            ePc4  = mPc + 32'd4;
            if (rd) begin
                eWr = 1'b1;
                if (!holding && !rdy) begin
                    if (!mDropping) mDropAddr = mPc;
                    mDropping = 1'b1;
                end else begin
                    mDropping = 1'b0;
                end
                mHeld.delete();
                mPc = tgt & 32'hFFFF_FFFC;
            end else if (st) begin
                if (mDropping) begin
                    if (rdy) mDropping = 1'b0;
                end else if (!holding && rdy) begin
                    mHeld.push_back(imemData);
                end
            end else begin
                eWr = 1'b1;
                if (holding) begin
                    eVal = 1'b1;
                    eInstr = mHeld.pop_front();
                    mPc = mPc + 32'd4;
                end else if (mDropping) begin
                    if (rdy) mDropping = 1'b0;
                end else if (rdy) begin
                    eVal = 1'b1;
                    eInstr = imemData;
                    mPc = mPc + 32'd4;
                end
            end
            if (eReq) chk("imemAddr", imemAddr, eAddr);
            if (eWr) chk("instrOut", instrOut, eInstr);
        end
        chk("imemReq", {31'h0, imemReq}, {31'h0, eReq});
        chk("ifidWrite", {31'h0, ifidWrite}, {31'h0, eWr});
        chk("validOut", {31'h0, validOut}, {31'h0, eVal});
        chk("pcPlus4Out", pcPlus4Out, ePc4);

        if (memBusy) begin
            if (rdy) memBusy = 1'b0;
            else memCnt--;
        end
    endtask

    initial begin
        // Reset, then zero-wait fetch of 0, 4, 8.
        latFixed = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("wrapRstReq", {31'h0, req2}, 32'h0);
        chk("wrapRstWr", {31'h0, wr2}, 32'h0);
        cycle(0, 0, 0, 0);
        chk("firstInstr", instrOut, 32'h2210_0002);
        chk("wrapPc4", pc4b, 32'h0);
        chk("wrapAddr", addr2, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("thirdPc4", pcPlus4Out, 32'd12);

        // Two wait states at 0xC.
        latFixed = 2;
        repeat (3) cycle(0, 0, 0, 0);

        // Stall for 3 cycles coinciding with completion at 0x10, then release.
        latFixed = 0;
        repeat (3) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("holdPc4", pcPlus4Out, 32'h14);
        repeat (3) cycle(0, 0, 0, 0);

        // Redirect to 0x103 while 0x20 is pending; late response discarded.
        latFixed = 3;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0103);
        latFixed = 0;
        repeat (4) cycle(0, 0, 0, 0);

        // Redirect and stall together while in HOLD.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h0000_0200);
        cycle(0, 0, 0, 0);
        chk("redirHoldAddr", pcPlus4Out, 32'h204);

        // Reset mid-DROP.
        latFixed = 3;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0300);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        latFixed = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Reset mid-HOLD.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);

        // Randomized traffic.
        latFixed = -1;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  $urandom());
        end
        chk("wrapPc4End", pc4b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a request/ready handshake with instruction memory.
- Each cycle it presents {instruction, PC+4} plus a load enable to IF/ID.
- Handles hazard-unit stalls, branch/jump redirects from ID, and variable memory latency by inserting NOP bubbles.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC, do not load IF/ID.
- redirect  input  1  ID resolved taken branch/jump this cycle.
- redirectTarget  input  32  new PC when redirect=1; bits [1:0] forced to 00.
- imemReq  output  1  instruction memory request.
- imemAddr  output  32  word address of request; stable while imemReq=1 and imemReady=0.
- imemReady  input  1  transfer completes in any cycle with imemReq and imemReady both high.
- imemData  input  32  instruction word, valid in the completing cycle.
- instrOut  output  32  to IF/ID instrIn.
- pcPlus4Out  output  32  to IF/ID pcPlus4In.
- ifidWrite  output  1  to IF/ID write enable.
- validOut  output  1  instrOut is a real instruction; 0 means NOP bubble.

Behaviour:
- Registers:
  - pc, 32 bits.
  - holdInstr, 32 bits.
  - state: FETCH, HOLD, DROP.
- Reset, while reset=1:
  - Next-edge values: pc=RESET_PC, state=FETCH, holdInstr=0.
  - Outputs forced: imemReq=0, ifidWrite=0, validOut=0, instrOut=0, pcPlus4Out=0.
  - Any in-flight memory request is abandoned; its response is ignored.
- Deliver condition: (state=FETCH and imemReady) or state=HOLD.
- Delivered word: imemData in FETCH, holdInstr in HOLD.
- pcPlus4Out = pc+4, computed modulo 2^32, so 32'hFFFFFFFC+4 = 0.
- Bubble: instrOut=32'h0, validOut=0.
- imemReq=1 in FETCH and DROP (outside reset), 0 in HOLD. imemAddr=pc in FETCH. In DROP, imemAddr holds the address of the abandoned request.
- Priority per cycle: reset > redirect > stall > normal.
- Redirect=1 (any state):
  - pc <= {redirectTarget[31:2],2'b00}.
  - ifidWrite=1 with a bubble, flushing the wrong-path slot; holdInstr is discarded.
  - Next state: DROP if state=FETCH or DROP and the request does not complete this cycle; otherwise FETCH.
- Stall=1, no redirect: ifidWrite=0, pc unchanged.
  - FETCH with imemReady: holdInstr <= imemData, go to HOLD.
  - HOLD stays HOLD; DROP behaves as normal.
- Normal (no stall, no redirect): ifidWrite=1 every cycle.
  - FETCH with imemReady: deliver imemData with validOut=1, pc <= pc+4, stay FETCH. Back-to-back zero-wait fetch gives 1 instruction per cycle.
  - FETCH without imemReady: bubble, pc unchanged.
  - HOLD: deliver holdInstr with validOut=1, pc <= pc+4, go to FETCH. The new request issues next cycle.
  - DROP: bubble. On imemReady, data is discarded and state goes to FETCH; otherwise stay DROP.
- Latency: instruction at address A is presented to IF/ID in the same cycle its memory transfer completes, unless held by stall.
- Invariants:
  - validOut=1 implies ifidWrite=1.
  - A wrong-path or dropped word never reaches IF/ID with validOut=1.
  - Each accepted instruction is delivered exactly once.

Test Plan:
- Reset then zero-wait memory returning 32'h22100002, 32'h22100003, 32'h22100004:
  - IF/ID receives them on consecutive cycles with pcPlus4Out 4, 8, 12.
  - imemAddr sequence is 0, 4, 8.
- Memory with imemReady delayed 2 cycles:
  - Two bubbles (ifidWrite=1, validOut=0, instrOut=0).
  - Then the instruction with validOut=1; imemAddr held stable throughout.
- stall=1 for 3 cycles coinciding with completion of fetch at 0x10:
  - ifidWrite=0 for 3 cycles, state HOLD, imemReq=0.
  - On release, holdInstr is delivered with pcPlus4Out=0x14; next imemAddr=0x14.
- redirect=1 with target 0x103 while a request to 0x20 is pending:
  - Bubble written, pc becomes 0x100, state DROP.
  - The late 0x20 response is discarded; next request address is 0x100.
- Redirect and stall asserted in the same cycle, HOLD state: redirect wins, holdInstr is dropped, bubble is written, next fetch targets redirectTarget.
- Reset asserted mid-DROP and mid-HOLD:
  - Next cycle pc=RESET_PC, state FETCH, all outputs 0 during reset.
  - RESET_PC=32'hFFFFFFFC: pcPlus4Out wraps to 0.
